// File: rtl/serial_tx_pkg.sv
// Shared encodings for the serial frame transmitter: FSM state codes and line levels.
package serial_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/serial_tx_frame_if.sv
// Producer-to-transmitter bus for serial_tx_frame plus the serial line outputs.
// Handshake: a word transfers on the rising edge where VALID=1 and READY=1; VALID while READY=0 is dropped.
interface serial_tx_frame_if #(parameter int DATA_BITS = 8);
  logic [DATA_BITS-1:0] DATA_IN;
  logic                 VALID;
  logic                 READY;
  logic                 TX;
  logic                 BUSY;

  modport master (output DATA_IN, VALID, input READY, TX, BUSY);
  modport slave  (input DATA_IN, VALID, output READY, TX, BUSY);
endinterface

// File: rtl/serial_baud_tick.sv
// Bit-period down-counter: TICK pulses on the last cycle of each CLKS_PER_BIT window while EN is high.
module serial_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic C,
  input  logic RN,
  input  logic EN,
  output logic TICK
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] TOP = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge C or negedge RN) begin
    if (!RN) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // Held at TOP while disabled so the first enabled cycle starts a full bit period.
  always_comb begin
    cnt_d = cnt_q;
    if (!EN || cnt_q == '0) cnt_d = TOP;
    else                    cnt_d = cnt_q - CW'(1);
  end

  assign TICK = EN && (cnt_q == '0);

endmodule

// File: rtl/serial_tx_frame.sv
// Parallel-to-serial frame transmitter: start bit, DATA_BITS LSB first, stop bit.
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit between data and stop.
module serial_tx_frame
  import serial_tx_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic               C,
  input  logic               RN,
  serial_tx_frame_if.slave   bus,
  output state_e             dbg_state
);

  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  state_e               state_q, state_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 tick;
  logic                 baud_en;
`ifdef SERIAL_TX_PARITY_EN
  logic                 par_q, par_d;
`endif

  assign baud_en = (state_q != ST_IDLE);

  serial_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .C    (C),
    .RN   (RN),
    .EN   (baud_en),
    .TICK (tick)
  );

  always_ff @(posedge C or negedge RN) begin
    if (!RN) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      sh_q      <= '0;
`ifdef SERIAL_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sh_q      <= sh_d;
`ifdef SERIAL_TX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sh_d      = sh_q;
`ifdef SERIAL_TX_PARITY_EN
    par_d     = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.VALID) begin
          state_d = ST_START;
          sh_d    = bus.DATA_IN;
`ifdef SERIAL_TX_PARITY_EN
          par_d   = ^bus.DATA_IN;
`endif
        end
      end
      ST_START: if (tick) state_d = ST_DATA;
      ST_DATA: begin
        if (tick) begin
          sh_d = {1'b0, sh_q[DATA_BITS-1:1]};
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
`ifdef SERIAL_TX_PARITY_EN
            state_d   = ST_PARITY;
`else
            state_d   = ST_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      ST_PARITY: if (tick) state_d = ST_STOP;
`endif
      ST_STOP: if (tick) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // TX decodes straight from state so an asynchronous reset returns the line to idle at once.
  always_comb begin
    bus.READY = (state_q == ST_IDLE);
    bus.BUSY  = (state_q != ST_IDLE);
    dbg_state = state_q;
    case (state_q)
      ST_IDLE:   bus.TX = LINE_IDLE;
      ST_START:  bus.TX = START_BIT;
      ST_DATA:   bus.TX = sh_q[0];
`ifdef SERIAL_TX_PARITY_EN
      ST_PARITY: bus.TX = par_q;
`endif
      ST_STOP:   bus.TX = STOP_BIT;
      default:   bus.TX = LINE_IDLE;
    endcase
  end

endmodule

// File: tb/tb_serial_tx_frame.sv
// Self-checking bench for serial_tx_frame: driver tasks push expected words, a line monitor decodes frames.
module tb_serial_tx_frame;
  import serial_tx_pkg::*;

  localparam int DB  = 8;
  localparam int CPB = 16;
`ifdef SERIAL_TX_PARITY_EN
  localparam int NBITS = DB + 3;
`else
  localparam int NBITS = DB + 2;
`endif
  localparam int FRAME = NBITS * CPB;

  logic   C = 1'b0;
  logic   RN = 1'b1;
  state_e dbg_state;
  int     cyc = 0;
  int     n_checks = 0;
  int     n_fail = 0;
  int     start_cyc = 0;
  logic [DB-1:0] exp_q[$];

  serial_tx_frame_if #(.DATA_BITS(DB)) bus ();

  serial_tx_frame #(.DATA_BITS(DB), .CLKS_PER_BIT(CPB)) dut (
    .C         (C),
    .RN        (RN),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset block
  always #5 C = ~C;
  always @(posedge C) cyc++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // driver: offer a word, wait for acceptance, push the expected frame, then scramble DATA_IN
  task automatic send(input logic [DB-1:0] w);
    logic acc;
    int   n;
    @(negedge C);
    bus.DATA_IN = w;
    bus.VALID   = 1'b1;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 3 * FRAME) begin
      acc = bus.READY;
      @(posedge C);
      n++;
      if (!acc) @(negedge C);
    end
    if (acc) exp_q.push_back(w);
    else     check("accept_timeout", 32'd0, 32'd1);
    #1;
    bus.VALID   = 1'b0;
    bus.DATA_IN = DB'($urandom_range(0, 255));
  endtask

  // monitor + scoreboard: decode one frame from TX and compare with the queue head
  task automatic mon_frame();
    logic [NBITS-1:0] slot;
    logic [DB-1:0]    d;
    logic [DB-1:0]    exp;
    logic             b;
    int               n;
    int               unstable;
    int               not_busy;
    n = 0;
    @(negedge C);
    while (bus.TX !== 1'b0 && n < 4 * FRAME) begin
      @(negedge C);
      n++;
    end
    if (bus.TX !== 1'b0) begin
      check("start_timeout", 32'd0, 32'd1);
      return;
    end
    start_cyc = cyc;
    unstable  = 0;
    not_busy  = 0;
    for (int i = 0; i < NBITS; i++) begin
      b = bus.TX;
      if (bus.READY !== 1'b0 || bus.BUSY !== 1'b1) not_busy++;
      for (int k = 1; k < CPB; k++) begin
        @(negedge C);
        if (bus.TX !== b) unstable++;
        if (bus.READY !== 1'b0 || bus.BUSY !== 1'b1) not_busy++;
      end
      slot[i] = b;
      @(negedge C);
    end
    check("bit_timing_unstable", unstable, 0);
    check("busy_during_frame", not_busy, 0);
    check("ready_after_frame", bus.READY, 1'b1);
    check("start_bit", slot[0], START_BIT);
    check("stop_bit", slot[NBITS-1], STOP_BIT);
    for (int j = 0; j < DB; j++) d[j] = slot[1+j];
    if (exp_q.size() == 0) begin
      check("unexpected_frame", d, 32'hFFFF_FFFF);
    end else begin
      exp = exp_q.pop_front();
      check("data", d, exp);
`ifdef SERIAL_TX_PARITY_EN
      check("parity_bit", slot[DB+1], ^exp);
`endif
    end
  endtask

  task automatic idle_watch(input int cycles);
    int bad = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge C);
      if (bus.TX !== 1'b1 || bus.READY !== 1'b1) bad++;
    end
    check("no_queued_frame", bad, 0);
  endtask

  initial begin
    int p;
    int n;
    bus.VALID   = 1'b0;
    bus.DATA_IN = '0;

    // reset then idle
    #1 RN = 1'b0;
    #1;
    check("async_rst_tx", bus.TX, 1'b1);
    repeat (3) begin
      @(negedge C);
      check("rst_tx", bus.TX, 1'b1);
      check("rst_ready", bus.READY, 1'b1);
      check("rst_busy", bus.BUSY, 1'b0);
      check("rst_state", dbg_state, ST_IDLE);
    end
    RN = 1'b1;
    repeat (50) begin
      @(negedge C);
      check("idle_tx", bus.TX, 1'b1);
      check("idle_ready", bus.READY, 1'b1);
      check("idle_busy", bus.BUSY, 1'b0);
    end

    // single frame
    fork
      send(8'hA5);
      mon_frame();
    join

    // back-to-back with VALID held
    fork
      begin send(8'h00); send(8'hFF); end
      begin
        mon_frame();
        p = start_cyc;
        mon_frame();
        check("b2b_gap", start_cyc - p, FRAME + 1);
      end
    join

    // request during a frame is dropped
    fork
      begin
        send(8'h96);
        repeat (30) @(negedge C);
        bus.DATA_IN = 8'h3C;
        bus.VALID   = 1'b1;
        @(negedge C);
        bus.VALID   = 1'b0;
      end
      begin
        mon_frame();
        idle_watch(2 * FRAME);
      end
    join
    check("exp_q_empty_after_drop", exp_q.size(), 0);

    // reset mid-frame
    send(8'h55);
    n = 0;
    @(negedge C);
    while (bus.TX !== 1'b0 && n < 4 * FRAME) begin
      @(negedge C);
      n++;
    end
    check("pre_reset_start_seen", bus.TX, 1'b0);
    repeat (40) @(negedge C);
    check("pre_reset_tx", bus.TX, 1'b0);
    @(posedge C);
    #2 RN = 1'b0;
    #1;
    check("midframe_async_tx", bus.TX, 1'b1);
    check("midframe_async_ready", bus.READY, 1'b1);
    check("midframe_async_state", dbg_state, ST_IDLE);
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    repeat (3) @(negedge C);
    RN = 1'b1;
    @(negedge C);
    check("post_reset_ready", bus.READY, 1'b1);
    check("post_reset_tx", bus.TX, 1'b1);
    fork
      send(8'hC3);
      mon_frame();
    join

`ifdef SERIAL_TX_PARITY_EN
    fork
      begin send(8'h07); send(8'h03); end
      begin mon_frame(); mon_frame(); end
    join
`endif

    // random back-to-back traffic
    fork
      for (int i = 0; i < 6; i++) send(DB'($urandom_range(0, 255)));
      for (int i = 0; i < 6; i++) mon_frame();
    join

    check("exp_q_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
